// File: rtl/gpr_pkg.sv
// Shared constants and index type for the general-purpose register file.
package gpr_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_COUNT = 32;

    typedef logic [4:0] gpr_idx_t;

    localparam gpr_idx_t GPR_ZERO = '0;

endpackage

// File: rtl/gpr_file_mp_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, and a same-cycle issue wins.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int RegCount = REG_COUNT,
    parameter int NumWrite = 1,
    parameter int AddrW    = $clog2(RegCount)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NumWrite-1:0]            wr_en,
    input  logic [NumWrite-1:0][AddrW-1:0] wr_addr,
    input  logic                           iss_en,
    input  logic [AddrW-1:0]               iss_addr,
    output logic [RegCount-1:0]            busy_vec,
    output logic [RegCount-1:0]            next_busy
);

    logic [RegCount-1:0] r_busy;
    logic [RegCount-1:0] w_clr;
    logic [RegCount-1:0] w_set;

    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int r = 0; r < RegCount; r++) begin
            for (int k = 0; k < NumWrite; k++) begin
                if (wr_en[k] && (wr_addr[k] == AddrW'(r))) begin
                    w_clr[r] = 1'b1;
                end
            end
            if (iss_en && (iss_addr == AddrW'(r)) && (iss_addr != AddrW'(GPR_ZERO))) begin
                w_set[r] = 1'b1;
            end
        end
        next_busy    = (r_busy & ~w_clr) | w_set;
        next_busy[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
        end else begin
            r_busy <= next_busy;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port register file with registered, stallable, write-first reads and x0 tied to zero.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int WordSize = WORD_SIZE,
    parameter int RegCount = REG_COUNT,
    parameter int NumRead  = 2,
    parameter int NumWrite = 1,
    parameter int AddrW    = $clog2(RegCount)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              rd_en,
    input  logic [NumRead-1:0][AddrW-1:0]     rs_addr,
    output logic [NumRead-1:0][WordSize-1:0]  rs_data,
    output logic [NumRead-1:0]                rs_busy,
    input  logic [NumWrite-1:0]               wr_en,
    input  logic [NumWrite-1:0][AddrW-1:0]    wr_addr,
    input  logic [NumWrite-1:0][WordSize-1:0] wr_data,
    input  logic                              iss_en,
    input  logic [AddrW-1:0]                  iss_addr,
    output logic [RegCount-1:0]               busy_vec
);

    logic [WordSize-1:0] r_regs     [RegCount];
    logic [WordSize-1:0] w_next_reg [RegCount];
    logic [RegCount-1:0] w_next_busy;

    logic [NumRead-1:0][WordSize-1:0] r_rs_data;
    logic [NumRead-1:0]               r_rs_busy;

    gpr_scoreboard #(
        .RegCount (RegCount),
        .NumWrite (NumWrite),
        .AddrW    (AddrW)
    ) u_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .busy_vec  (busy_vec),
        .next_busy (w_next_busy)
    );

    // Ascending port scan so the highest-numbered writer lands last and wins.
    always_comb begin
        for (int r = 0; r < RegCount; r++) begin
            w_next_reg[r] = r_regs[r];
            for (int k = 0; k < NumWrite; k++) begin
                if (wr_en[k] && (wr_addr[k] == AddrW'(r))) begin
                    w_next_reg[r] = wr_data[k];
                end
            end
        end
        w_next_reg[0] = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_regs <= '{default: '0};
        end else begin
            r_regs <= w_next_reg;
        end
    end

    // Reads sample post-write state, giving write-first bypass for free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rs_data <= '0;
            r_rs_busy <= '0;
        end else if (rd_en) begin
            for (int p = 0; p < NumRead; p++) begin
                r_rs_data[p] <= w_next_reg[rs_addr[p]];
                r_rs_busy[p] <= w_next_busy[rs_addr[p]];
            end
        end
    end

    assign rs_data = r_rs_data;
    assign rs_busy = r_rs_busy;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp with two read and two write ports.
module tb_gpr_file_mp;
    import gpr_pkg::*;

    logic                  clk;
    logic                  rstn;
    logic                  rd_en;
    logic [1:0][4:0]       rs_addr;
    logic [1:0][31:0]      rs_data;
    logic [1:0]            rs_busy;
    logic [1:0]            wr_en;
    logic [1:0][4:0]       wr_addr;
    logic [1:0][31:0]      wr_data;
    logic                  iss_en;
    gpr_idx_t              iss_addr;
    logic [31:0]           busy_vec;

    int checks = 0;
    int errors = 0;

    gpr_file_mp #(
        .WordSize (32),
        .RegCount (32),
        .NumRead  (2),
        .NumWrite (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_en    (rd_en),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    initial begin
        rstn    = 1'b0;
        rd_en   = 1'b0;
        rs_addr = '0;
        idle_inputs();
        #22;
        rstn = 1'b1;
        #2;

        // Reset state seen through both read ports
        rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs_addr[0] = 5'(i);
            rs_addr[1] = 5'(31 - i);
            step();
            check("rst_data0", 64'(rs_data[0]), 64'h0);
            check("rst_data1", 64'(rs_data[1]), 64'h0);
            check("rst_busy",  64'(rs_busy), 64'h0);
            check("rst_bvec",  64'(busy_vec), 64'h0);
        end

        // Write then read
        rs_addr = '0;
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        step();
        idle_inputs();
        rs_addr[0] = 5'd5;
        step();
        check("wr_rd_r5", 64'(rs_data[0]), 64'hDEADBEEF);

        // x0 protection
        wr_en = 2'b10; wr_addr[1] = 5'd0; wr_data[1] = 32'h1234;
        rs_addr[0] = 5'd0;
        step();
        check("x0_bypass", 64'(rs_data[0]), 64'h0);
        idle_inputs();
        step();
        check("x0_read", 64'(rs_data[0]), 64'h0);

        // Same-index collision plus bypass on port 1
        wr_en = 2'b11;
        wr_addr[0] = 5'd7; wr_data[0] = 32'hA;
        wr_addr[1] = 5'd7; wr_data[1] = 32'hB;
        rs_addr[1] = 5'd7;
        step();
        check("coll_bypass", 64'(rs_data[1]), 64'hB);
        idle_inputs();
        rs_addr[0] = 5'd7;
        rs_addr[1] = 5'd5;
        step();
        check("coll_stored", 64'(rs_data[0]), 64'hB);
        check("r5_port1",    64'(rs_data[1]), 64'hDEADBEEF);

        // Stall hold
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h55;
        rs_addr[0] = 5'd3;
        step();
        check("stall_cap", 64'(rs_data[0]), 64'h55);
        rd_en = 1'b0;
        rs_addr[0] = 5'd5;
        wr_en = 2'b10; wr_addr[1] = 5'd3; wr_data[1] = 32'h66;
        step();
        check("stall_hold1", 64'(rs_data[0]), 64'h55);
        idle_inputs();
        step();
        check("stall_hold2", 64'(rs_data[0]), 64'h55);
        rd_en = 1'b1;
        rs_addr[0] = 5'd3;
        step();
        check("stall_release", 64'(rs_data[0]), 64'h66);

        // Scoreboard
        iss_en = 1'b1; iss_addr = 5'd9;
        rs_addr[1] = 5'd9;
        step();
        check("sb_set",       64'(busy_vec), 64'h0000_0200);
        check("sb_rd_set",    64'(rs_busy[1]), 64'h1);
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
        step();
        check("sb_set_clr",   64'(busy_vec[9]), 64'h1);
        check("sb_rd_setclr", 64'(rs_busy[1]), 64'h1);
        iss_en = 1'b0;
        wr_data[0] = 32'h9A;
        step();
        check("sb_clr",       64'(busy_vec[9]), 64'h0);
        check("sb_rd_clr",    64'(rs_busy[1]), 64'h0);
        check("sb_data",      64'(rs_data[1]), 64'h9A);
        idle_inputs();
        iss_en = 1'b1; iss_addr = 5'd0;
        rs_addr[1] = 5'd0;
        step();
        check("sb_x0",        64'(busy_vec), 64'h0);
        check("sb_rd_x0",     64'(rs_busy[1]), 64'h0);
        iss_addr = 5'd12;
        step();
        check("sb_set12",     64'(busy_vec), 64'h0000_1000);
        idle_inputs();
        wr_en = 2'b10; wr_addr[1] = 5'd12; wr_data[1] = 32'hC0;
        step();
        check("sb_clr12_p1",  64'(busy_vec), 64'h0);
        idle_inputs();
        wr_en = 2'b01; wr_addr[0] = 5'd13; wr_data[0] = 32'hD;
        rs_addr[0] = 5'd13;
        step();
        check("sb_idle_wr",   64'(busy_vec), 64'h0);
        check("idle_wr_data", 64'(rs_data[0]), 64'hD);

        // Async reset mid-operation
        idle_inputs();
        iss_en = 1'b1; iss_addr = 5'd9;
        rs_addr[0] = 5'd5;
        rs_addr[1] = 5'd9;
        step();
        check("pre_rst_data", 64'(rs_data[0]), 64'hDEADBEEF);
        check("pre_rst_bvec", 64'(busy_vec), 64'h0000_0200);
        check("pre_rst_busy", 64'(rs_busy[1]), 64'h1);
        wr_en = 2'b01; wr_addr[0] = 5'd11; wr_data[0] = 32'h1111;
        iss_addr = 5'd11;
        #2;
        rstn = 1'b0;
        #1;
        check("async_data0", 64'(rs_data[0]), 64'h0);
        check("async_busy",  64'(rs_busy), 64'h0);
        check("async_bvec",  64'(busy_vec), 64'h0);
        step();
        check("rst_held_bvec", 64'(busy_vec), 64'h0);
        idle_inputs();
        #3;
        rstn = 1'b1;
        rs_addr[0] = 5'd5;
        rs_addr[1] = 5'd11;
        step();
        check("post_rst_r5",  64'(rs_data[0]), 64'h0);
        check("post_rst_r11", 64'(rs_data[1]), 64'h0);
        check("post_rst_busy", 64'(rs_busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
Parametrised general-purpose register file for the next core generation.
- Configurable word size, register count, and numbers of read and write ports.
- Registered reads with stall/hold, write-first bypass and x0 hardwired to zero.
- A per-register busy scoreboard that the issue stage uses for hazard detection.
- Sits between decode/issue (read and issue ports) and writeback (write ports).

Parameters:
WordSize, 32, data width in bits
RegCount, 32, number of architectural registers (power of two, >=2)
NumRead, 2, number of read ports
NumWrite, 1, number of write ports
AddrW, $clog2(RegCount), register index width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
rd_en  input  1  1 = capture new read results; 0 = hold read outputs (stall)
rs_addr  input  NumRead x AddrW  read indices
rs_data  output  NumRead x WordSize  registered read data
rs_busy  output  NumRead  registered busy flag of each read register
wr_en  input  NumWrite  per-port write enable
wr_addr  input  NumWrite x AddrW  write indices
wr_data  input  NumWrite x WordSize  write data
iss_en  input  1  mark a destination register busy
iss_addr  input  AddrW  destination register being issued
busy_vec  output  RegCount  current scoreboard state, bit 0 always 0

Behaviour:
- Reset (rstn low, async): all registers 0, all busy bits 0, rs_data 0, rs_busy 0. Takes effect immediately, including mid-operation; no write or issue in that cycle survives.
- Register 0:
  - Reads always return 0 and busy 0.
  - Writes and issues to index 0 are ignored.
- Write:
  - On a rising edge with wr_en[k]=1, reg[wr_addr[k]] <= wr_data[k].
  - Several ports writing the same index in one cycle: the highest port index wins.
- Read latency: 1 cycle.
  - On an edge with rd_en=1, rs_data[p] <= value of reg[rs_addr[p]] after this cycle's writes are applied (write-first bypass).
  - The same-cycle write value is forwarded, using the same highest-port priority.
- Stall:
  - rd_en=0: rs_data and rs_busy hold their previous values.
  - Writes and issues still take effect while stalled.
- Scoreboard:
  - next_busy[r] = (busy[r] & ~clr[r]) | set[r].
  - clr[r] = any wr_en[k] with wr_addr[k]==r.
  - set[r] = iss_en with iss_addr==r, r!=0.
  - Set and clear on the same register in the same cycle: result is busy (new producer overrides the retiring one).
- rs_busy[p] is captured with rs_data and is the next_busy value of rs_addr[p] (post-update).
- busy_vec is the registered busy state; it is not bypassed.
- Writing a register that is not busy is legal: data is updated and busy stays 0.
- All index inputs are in range by construction (RegCount = 2^AddrW); no error path.

Decomposition:
- Package gpr_pkg holds:
  - default constants WORD_SIZE=32 and REG_COUNT=32;
  - the type gpr_idx_t (logic [4:0]) for the default configuration;
  - the constant GPR_ZERO=0.
- One natural sub-module, gpr_scoreboard: holds the busy vector and implements the set/clear/priority rule. It exposes busy_vec and the combinational next_busy for the read-capture path.
- Storage, write-priority merge and read/bypass muxing stay in gpr_file_mp.

Test Plan:
- Reset then read: reset, set rd_en=1 and read indices 0..31 on both ports → every rs_data=0, rs_busy=0, busy_vec=0.
- Write then read, plus x0 protection:
  - write 0xDEADBEEF to reg 5, then read reg 5 on port 0 next cycle → rs_data[0]=0xDEADBEEF after 1 edge;
  - write 0x1234 to reg 0 → later read of reg 0 returns 0.
- Bypass and write collision (NumWrite=2):
  - in one cycle, wr port0 writes reg 7=0xA and port1 writes reg 7=0xB while rs_addr[1]=7, rd_en=1 → rs_data[1]=0xB on that edge and reg 7 holds 0xB afterward.
- Stall hold:
  - capture reg 3=0x55, then drop rd_en;
  - change rs_addr and write reg 3=0x66 → rs_data holds 0x55;
  - raise rd_en → 0x66 next edge.
- Scoreboard:
  - iss reg 9 → busy_vec[9]=1;
  - same cycle: write reg 9 and issue reg 9 → busy_vec[9] stays 1;
  - write reg 9 with no issue → busy_vec[9]=0;
  - issue reg 0 → busy_vec[0]=0;
  - read reg 9 during the set cycle → rs_busy=1.
- Async reset mid-operation: assert rstn low between edges while regs and busy are nonzero → outputs go to 0 immediately, before the next clk edge.
